// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-RAM port arbiter: FSM states, grant
// encodings and the default bus widths used by the control unit and RAM model.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Winner pick for the RAM arbiter: CPU priority, with DMA forced once the CPU
// has been granted STARVE_MAX times while DMA was waiting.
module arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic take,
  output logic winner
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved = (starve_cnt == CNT_MAX);
    winner  = GRANT_CPU;
    if (dma_req && (!cpu_req || starved)) begin
      winner = GRANT_DMA;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (winner == GRANT_DMA) begin
        starve_cnt <= '0;
      end else if (dma_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port main RAM: latches the winning
// request, holds mem_en for WAIT_CYCLES cycles, then pulses the winner's ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [3:0]        wcnt_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              grant_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              any_req, take, last_beat, winner;

  arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .take    (take),
    .winner  (winner)
  );

  always_comb begin
    any_req   = cpu_req | dma_req;
    take      = (state_q == ST_IDLE) && any_req;
    last_beat = (state_q == ST_ACCESS) && (wcnt_q == '0);
    state_d   = state_q;
    case (state_q)
      ST_IDLE:   if (any_req)   state_d = ST_ACCESS;
      ST_ACCESS: if (last_beat) state_d = ST_RESP;
      ST_RESP:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wcnt_q      <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      grant_q     <= GRANT_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (take) begin
        grant_q <= winner;
        wcnt_q  <= WAIT_LOAD;
        if (winner == GRANT_DMA) begin
          lat_we_q    <= dma_we;
          lat_addr_q  <= dma_addr;
          lat_wdata_q <= dma_wdata;
        end else begin
          lat_we_q    <= cpu_we;
          lat_addr_q  <= cpu_addr;
          lat_wdata_q <= cpu_wdata;
        end
      end else if (state_q == ST_ACCESS && wcnt_q != '0) begin
        wcnt_q <= wcnt_q - 4'd1;
      end
      // Read data is taken on the last wait cycle, for the owner only.
      if (last_beat && !lat_we_q) begin
        if (grant_q == GRANT_DMA) begin
          dma_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & lat_we_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_ack   = (state_q == ST_RESP) && (grant_q == GRANT_CPU);
  assign dma_ack   = (state_q == ST_RESP) && (grant_q == GRANT_DMA);
  assign grant     = grant_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a timeline model of the
// arbitration rules, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 32;
  localparam int          W    = 2;
  localparam int          SMAX = 4;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack, mem_en, mem_we, busy, grant;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .STARVE_MAX(SMAX)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  // Extra builds for the wait-state extremes, driven by their own CPU request.
  logic          x1_req, x15_req;
  logic          w1_ack, w1_dack, w1_en, w1_we, w1_busy, w1_grant;
  logic          w15_ack, w15_dack, w15_en, w15_we, w15_busy, w15_grant;
  logic [AW-1:0] w1_addr, w15_addr;
  logic [DW-1:0] w1_rd, w1_drd, w1_wd, w15_rd, w15_drd, w15_wd;

  mem_port_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clock(Clock), .Reset_n(Reset_n),
    .cpu_req(x1_req), .cpu_we(1'b0), .cpu_addr(9'h001), .cpu_wdata(32'h0),
    .cpu_ack(w1_ack), .cpu_rdata(w1_rd),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(9'h000), .dma_wdata(32'h0),
    .dma_ack(w1_dack), .dma_rdata(w1_drd),
    .mem_en(w1_en), .mem_we(w1_we), .mem_addr(w1_addr), .mem_wdata(w1_wd),
    .mem_rdata(32'h0), .busy(w1_busy), .grant(w1_grant)
  );

  mem_port_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clock(Clock), .Reset_n(Reset_n),
    .cpu_req(x15_req), .cpu_we(1'b0), .cpu_addr(9'h001), .cpu_wdata(32'h0),
    .cpu_ack(w15_ack), .cpu_rdata(w15_rd),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(9'h000), .dma_wdata(32'h0),
    .dma_ack(w15_dack), .dma_rdata(w15_drd),
    .mem_en(w15_en), .mem_we(w15_we), .mem_addr(w15_addr), .mem_wdata(w15_wd),
    .mem_rdata(32'h0), .busy(w15_busy), .grant(w15_grant)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 9'h010) ? 32'hDEADBEEF : ({23'h0, a} ^ 32'hA5A50000);
  endfunction

  // Environment RAM written only by the DUT
  logic [DW-1:0] ram    [512];
  bit            ram_wr [512];
  assign mem_rdata = ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  always @(posedge Clock) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc;

  // Model: each access is a time window starting at its sample edge
  bit            has_acc, m_owner, m_we, m_grant;
  int            s_edge, free_edge, m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd, m_cpu_rdata, m_dma_rdata;
  logic [DW-1:0] exp_mem [512];
  bit            exp_wr  [512];

  bit c_pend, d_pend, rnd_en, rereq;
  int cpu_ack_e, dma_ack_e, en_cnt, we_cnt, cpu_ack_cnt, dma_ack_cnt;
  bit ack_seq[$];
  int ack_edges[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return exp_wr[a] ? exp_mem[a] : init_val(a);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 9'h1FF;
    return 9'($urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    cyc = 0; has_acc = 0; free_edge = 0; m_starve = 0; m_grant = 0;
    m_cpu_rdata = '0; m_dma_rdata = '0;
  endtask

  task automatic drive(input bit in_acc, input bit in_resp);
    if (in_resp) begin
      if (m_owner) d_pend = rereq; else c_pend = rereq;
    end
    if (rnd_en) begin
      if (!c_pend && $urandom_range(0, 9) < 6) begin
        c_pend = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rnd_addr(); cpu_wdata = $urandom;
      end
      if (!d_pend && $urandom_range(0, 9) < 5) begin
        d_pend = 1; dma_we = 1'($urandom_range(0, 1)); dma_addr = rnd_addr(); dma_wdata = $urandom;
      end
      // The owner may disturb its bus once latched; the DUT must ignore it.
      if (in_acc && $urandom_range(0, 1) == 1) begin
        if (m_owner) begin dma_addr = rnd_addr(); dma_wdata = $urandom; dma_we = ~dma_we; end
        else begin cpu_addr = rnd_addr(); cpu_wdata = $urandom; cpu_we = ~cpu_we; end
      end
    end
    cpu_req = c_pend;
    dma_req = d_pend;
  endtask

  task automatic step();
    int e;
    bit win, in_acc, in_resp;
    @(posedge Clock);
    e = cyc;
    cyc++;
    if (e >= free_edge && (cpu_req || dma_req)) begin
      win = dma_req && (!cpu_req || m_starve == SMAX);
      if (win) m_starve = 0;
      else if (dma_req && m_starve < SMAX) m_starve++;
      m_owner = win;
      m_we    = win ? dma_we : cpu_we;
      m_addr  = win ? dma_addr : cpu_addr;
      m_wdata = win ? dma_wdata : cpu_wdata;
      if (m_we) begin exp_mem[m_addr] = m_wdata; exp_wr[m_addr] = 1; end
      else m_rd = model_read(m_addr);
      has_acc = 1; s_edge = e; free_edge = e + W + 2; m_grant = win;
    end
    @(negedge Clock);
    in_acc  = has_acc && e >= s_edge && e < s_edge + W;
    in_resp = has_acc && e == s_edge + W;
    if (in_resp && !m_we) begin
      if (m_owner) m_dma_rdata = m_rd; else m_cpu_rdata = m_rd;
    end
    chk1("busy", busy, in_acc || in_resp);
    chk1("mem_en", mem_en, in_acc);
    chk1("mem_we", mem_we, in_acc && m_we);
    chk1("cpu_ack", cpu_ack, in_resp && !m_owner);
    chk1("dma_ack", dma_ack, in_resp && m_owner);
    chk1("grant", grant, m_grant);
    chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
    chk("dma_rdata", dma_rdata, m_dma_rdata);
    if (in_acc) begin
      chk("mem_addr", {23'h0, mem_addr}, {23'h0, m_addr});
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mem_en) en_cnt++;
    if (mem_we) we_cnt++;
    if (cpu_ack) begin cpu_ack_e = e; cpu_ack_cnt++; ack_seq.push_back(1'b0); ack_edges.push_back(e); end
    if (dma_ack) begin dma_ack_e = e; dma_ack_cnt++; ack_seq.push_back(1'b1); ack_edges.push_back(e); end
    drive(in_acc, in_resp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [9:0] exp_seq;
    int a1, a15, n1, n15;
    Reset_n = 0; c_pend = 0; d_pend = 0; rnd_en = 0; rereq = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    x1_req = 0; x15_req = 0;
    cyc = 0;
    repeat (2) @(negedge Clock);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_acks", cpu_ack | dma_ack, 1'b0);
    chk1("rst_grant", grant, 1'b0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 32'h0);
    chk("rst_mem_addr", {23'h0, mem_addr}, 32'h0);
    Reset_n = 1;
    model_reset();

    // CPU read of 0x010
    cpu_we = 0; cpu_addr = 9'h010; c_pend = 1; cpu_req = 1;
    en_cnt = 0; dma_ack_cnt = 0; cpu_ack_e = -1;
    repeat (6) step();
    chk("t1_ack_cycle", 32'(cpu_ack_e + 1), 32'd3);
    chk("t1_en_width", 32'(en_cnt), 32'd2);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dma_acks", 32'(dma_ack_cnt), 32'd0);

    // DMA write then CPU read of the same word
    dma_we = 1; dma_addr = 9'h1FF; dma_wdata = 32'h12345678; d_pend = 1; dma_req = 1;
    we_cnt = 0;
    repeat (5) step();
    chk("t2_we_width", 32'(we_cnt), 32'd2);
    cpu_we = 0; cpu_addr = 9'h1FF; c_pend = 1; cpu_req = 1;
    repeat (5) step();
    chk("t2_cpu_rdata", cpu_rdata, 32'h12345678);
    chk("t2_dma_rdata", dma_rdata, 32'h0);
    chk("t2_we_total", 32'(we_cnt), 32'd2);

    // Both requesters held: starvation guard pattern C,C,C,C,D repeating
    ack_seq.delete(); ack_edges.delete();
    cpu_we = 0; cpu_addr = 9'h005; dma_we = 0; dma_addr = 9'h006;
    c_pend = 1; d_pend = 1; cpu_req = 1; dma_req = 1; rereq = 1;
    for (int i = 0; i < 60 && ack_seq.size() < 10; i++) step();
    rereq = 0;
    exp_seq = 10'b1000010000;
    chk("t3_ack_count", 32'(ack_seq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < ack_seq.size()) chk1($sformatf("t3_grant%0d", i), ack_seq[i], exp_seq[i]);
    end
    for (int i = 1; i < 10; i++) begin
      if (i < ack_edges.size()) chk($sformatf("t3_gap%0d", i), 32'(ack_edges[i] - ack_edges[i-1]), 32'd4);
    end
    c_pend = 0; d_pend = 0; cpu_req = 0; dma_req = 0;
    repeat (2) step();

    // Simultaneous first request; CPU address disturbed mid-access
    cpu_ack_e = -100; dma_ack_e = -100;
    cpu_we = 0; cpu_addr = 9'h00A; dma_we = 0; dma_addr = 9'h00B;
    c_pend = 1; d_pend = 1; cpu_req = 1; dma_req = 1;
    step();
    cpu_addr = 9'h0F0;
    step();
    chk("t4_addr_hold", {23'h0, mem_addr}, 32'h00A);
    for (int i = 0; i < 20 && (c_pend || d_pend); i++) step();
    repeat (2) step();
    chk("t4_dma_after_cpu", 32'(dma_ack_e - cpu_ack_e), 32'd4);

    // Reset during the second ACCESS cycle
    cpu_we = 0; cpu_addr = 9'h003; c_pend = 1; cpu_req = 1;
    step(); step();
    #1 Reset_n = 0;
    #1;
    chk1("t5_mem_en", mem_en, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_acks", cpu_ack | dma_ack, 1'b0);
    c_pend = 0; cpu_req = 0;
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1;
    model_reset();
    cpu_ack_cnt = 0; dma_ack_cnt = 0;
    repeat (6) step();
    chk("t5_no_ack", 32'(cpu_ack_cnt + dma_ack_cnt), 32'd0);
    cpu_we = 0; cpu_addr = 9'h010; c_pend = 1; cpu_req = 1; cpu_ack_e = -1;
    cyc = 0; free_edge = 0;
    repeat (5) step();
    chk("t5_resume_ack", 32'(cpu_ack_e + 1), 32'd3);
    chk("t5_resume_rdata", cpu_rdata, 32'hDEADBEEF);

    // Random traffic
    rnd_en = 1;
    repeat (3000) step();
    rnd_en = 0;
    for (int i = 0; i < 40 && (c_pend || d_pend); i++) step();
    repeat (3) step();

    // Wait-state extremes
    a1 = -1; a15 = -1; n1 = 0; n15 = 0;
    x1_req = 1; x15_req = 1;
    for (int k = 0; k < 25; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (w1_en) n1++;
      if (w15_en) n15++;
      if (w1_ack && a1 < 0) a1 = k;
      if (w15_ack && a15 < 0) a15 = k;
      if (w1_ack) x1_req = 0;
      if (w15_ack) x15_req = 0;
    end
    chk("t6_w1_ack_cycle", 32'(a1 + 1), 32'd2);
    chk("t6_w15_ack_cycle", 32'(a15 + 1), 32'd16);
    chk("t6_w1_en_width", 32'(n1), 32'd1);
    chk("t6_w15_en_width", 32'(n15), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
